ob_mk_match: RTL and testbench
==============================

Name: ob_mk_match

Overview:
- Initiator/controller that drives one resting-side order table through its head-pop, head-push, insert and cancel interface.
- Accepts order commands on a valid/ready channel: INSERT (rest an order), CANCEL (by UID) and MATCH (aggress against the table head).
- Sequences the table strobes one operation per cycle and emits a per-fill trade/status response stream with backpressure.
- Sits between the order decoder and the per-side table instance.

Parameters:
- RESTING_IS_BID, 1, 1: table holds bids, so an aggressor crosses when head.price >= cmd price. 0: table holds asks, so it crosses when head.price <= cmd price.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_opcode  in  2  01 INSERT, 10 CANCEL, 11 MATCH, 00 reserved (rejected)
- cmd_uid  in  ob_pkg::uid_t  order UID
- cmd_price  in  ob_pkg::price_t  limit price
- cmd_quantity  in  ob_pkg::quantity_t  quantity
- tbl_head_vld_r  in  1  table head valid (registered)
- tbl_head_r  in  ob_pkg::table_t  table head entry (registered)
- tbl_full_w  in  1  table next-state full
- tbl_head_pop  out  1  pop head
- tbl_head_push  out  1  push entry to head
- tbl_head_push_tbl  out  ob_pkg::table_t  pushed entry
- tbl_insert  out  1  append to tail
- tbl_insert_tbl  out  ob_pkg::table_t  appended entry
- tbl_cancel  out  1  cancel lookup strobe
- tbl_cancel_uid  out  ob_pkg::uid_t  cancel UID
- tbl_cancel_hit_w  in  1  cancel hit (combinational, same cycle)
- tbl_cancel_hit_tbl_w  in  ob_pkg::table_t  hit entry
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_type  out  3  0 INSERT_ACK, 1 REJECT, 2 CANCEL_HIT, 3 CANCEL_MISS, 4 TRADE, 5 MATCH_DONE
- rsp_uid  out  ob_pkg::uid_t  command UID
- rsp_maker_uid  out  ob_pkg::uid_t  resting UID (TRADE, CANCEL_HIT), else 0
- rsp_price  out  ob_pkg::price_t  trade price = resting price; else command price
- rsp_quantity  out  ob_pkg::quantity_t  fill qty (TRADE), cancelled qty (CANCEL_HIT), remaining aggressor qty (MATCH_DONE), else 0

Behaviour:
- Reset (synchronous): state IDLE, rsp_vld=0, all tbl_* strobes and payloads 0, full_q=0, internal registers 0. cmd_rdy=0 while rst is asserted. Reset mid-sequence abandons the operation; the table sees no strobe in the reset cycle and no response is emitted.
- full_q is tbl_full_w registered every cycle.
- At most one tbl_* strobe is asserted per cycle. Strobes are single-cycle pulses.
- IDLE: cmd_rdy=1. On cmd_vld&cmd_rdy, latch cmd into cmd_q and rem_q=cmd_quantity, then dispatch:
  - INSERT -> INS
  - CANCEL -> CXL
  - MATCH -> EVAL
  - 00 -> RSP with REJECT
- INS: if full_q or quantity==0, go to RSP with REJECT. Else pulse tbl_insert with {uid,price,quantity}, then RSP with INSERT_ACK.
- CXL: pulse tbl_cancel with cmd_q.uid. Sample tbl_cancel_hit_w and tbl_cancel_hit_tbl_w in the same cycle, then RSP with CANCEL_HIT (qty = hit entry quantity) or CANCEL_MISS.
- EVAL: entered only in the cycle after the latch or a table update, so head_r is settled.
  - Cross = tbl_head_vld_r & price test & rem_q!=0. If no cross, go to RSP with MATCH_DONE (qty = rem_q).
  - Else fill=min(rem_q, head.quantity). Drive rsp_vld with TRADE and hold the payload stable until rsp_rdy.
  - On handshake: pulse tbl_head_pop and set rem_q -= fill.
  - If head.quantity > fill, latch resid = head.quantity - fill and the head entry, then go to PUSH. Else stay in EVAL; the next cycle re-evaluates the new head.
- PUSH: pulse tbl_head_push with the latched head entry and quantity=resid, preserving priority. Then RSP with MATCH_DONE, qty 0.
- RSP: rsp_vld=1 with the payload held stable until rsp_rdy, then IDLE. cmd_rdy=0 in every state except IDLE.
- Arithmetic: quantities are unsigned; fill ≤ rem_q, so rem_q never underflows.
- Empty table (head_vld_r=0) on MATCH: MATCH_DONE with the full quantity, no strobes.
- Minimum latencies:
  - INSERT, CANCEL: accept to response 2 cycles.
  - MATCH with no cross: 2 cycles.
  - Each full fill: 1 cycle plus backpressure.

Optional Feature:
- OB_MK_MATCH_STATS_EN defined: adds outputs stat_trades_r (32b, TRADE handshakes) and stat_volume_r (ob_pkg::accum_quantity_t, sum of fill quantities). Both reset to 0, saturate at all-ones and never wrap.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Bid table, INSERT uid=1 price=100 qty=10 -> tbl_insert pulse with {1,100,10}, rsp INSERT_ACK uid=1 after 2 cycles.
- tbl_full_w held 1, INSERT uid=2 -> no tbl_insert, rsp REJECT uid=2.
- Head {uid=1,p=100,q=10}, MATCH uid=7 p=95 q=4 -> TRADE maker=1 p=100 q=4; pop then push {1,100,6}; MATCH_DONE q=0.
- Heads {1,100,3} then {2,99,5}, MATCH uid=8 p=99 q=10 -> TRADE q=3 maker=1, TRADE q=5 maker=2, two pops, MATCH_DONE q=2.
- CANCEL uid=1 with a hit entry of q=6 -> tbl_cancel pulse, CANCEL_HIT maker=1 q=6. CANCEL uid=9 with no hit -> CANCEL_MISS.
- rsp_rdy=0 for 5 cycles during a TRADE -> payload stable, no tbl_head_pop until the handshake. Assert rst mid-EVAL -> all strobes 0, rsp_vld=0, cmd_rdy=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/ob_mk_match.sv
// ob_mk_match: per-side order table controller.
// Accepts INSERT / CANCEL / MATCH commands on a valid/ready channel, drives the
// resting-side table through its pop / push / insert / cancel strobes (at most
// one per cycle) and returns a per-fill trade/status response stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_*                    command channel (opcode 01 INSERT, 10 CANCEL, 11 MATCH)
//   tbl_head_vld_r/_r        registered table head
//   tbl_full_w               table next-state full
//   tbl_head_pop/_push/_tbl  head pop / head push strobes and pushed entry
//   tbl_insert/_tbl          tail append strobe and entry
//   tbl_cancel/_uid          cancel lookup strobe and UID
//   tbl_cancel_hit_w/_tbl_w  same-cycle cancel lookup result
//   rsp_*                    response channel (valid/ready)
//
// Optional build macro OB_MK_MATCH_STATS_EN adds stat_trades_r / stat_volume_r
// (saturating trade count and traded volume).
`timescale 1ns/1ps

package ob_pkg;
    typedef logic [15:0] uid_t;
    typedef logic [15:0] price_t;
    typedef logic [15:0] quantity_t;
    typedef logic [47:0] accum_quantity_t;
    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t quantity;
    } table_t;
endpackage

module ob_mk_match #(
    parameter bit RESTING_IS_BID = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [1:0]              cmd_opcode,
    input  ob_pkg::uid_t            cmd_uid,
    input  ob_pkg::price_t          cmd_price,
    input  ob_pkg::quantity_t       cmd_quantity,
    input  logic                    tbl_head_vld_r,
    input  ob_pkg::table_t          tbl_head_r,
    input  logic                    tbl_full_w,
    output logic                    tbl_head_pop,
    output logic                    tbl_head_push,
    output ob_pkg::table_t          tbl_head_push_tbl,
    output logic                    tbl_insert,
    output ob_pkg::table_t          tbl_insert_tbl,
    output logic                    tbl_cancel,
    output ob_pkg::uid_t            tbl_cancel_uid,
    input  logic                    tbl_cancel_hit_w,
    input  ob_pkg::table_t          tbl_cancel_hit_tbl_w,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [2:0]              rsp_type,
    output ob_pkg::uid_t            rsp_uid,
    output ob_pkg::uid_t            rsp_maker_uid,
    output ob_pkg::price_t          rsp_price,
    output ob_pkg::quantity_t       rsp_quantity
`ifdef OB_MK_MATCH_STATS_EN
    ,
    output logic [31:0]             stat_trades_r,
    output ob_pkg::accum_quantity_t stat_volume_r
`endif
);

    // state | meaning
    // IDLE  | ready for a command
    // INS   | insert: strobe tbl_insert or reject
    // CXL   | cancel: strobe tbl_cancel, sample the hit result
    // EVAL  | match: test head for a cross, present TRADE, pop on handshake
    // PUSH  | match: push the partially-filled head back to the front
    // RSP   | hold a registered status response until accepted

    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_CANCEL = 2'b10;
    localparam logic [1:0] OP_MATCH  = 2'b11;

    localparam logic [2:0] RSP_INSERT_ACK  = 3'd0;
    localparam logic [2:0] RSP_REJECT      = 3'd1;
    localparam logic [2:0] RSP_CANCEL_HIT  = 3'd2;
    localparam logic [2:0] RSP_CANCEL_MISS = 3'd3;
    localparam logic [2:0] RSP_TRADE       = 3'd4;
    localparam logic [2:0] RSP_MATCH_DONE  = 3'd5;

    typedef enum logic [2:0] {IDLE, INS, CXL, EVAL, PUSH, RSP} state_t;

    state_t            state_q;
    ob_pkg::uid_t      cmd_uid_q;
    ob_pkg::price_t    cmd_price_q;
    ob_pkg::quantity_t cmd_qty_q;
    ob_pkg::quantity_t rem_q;
    ob_pkg::quantity_t resid_q;
    ob_pkg::uid_t      push_uid_q;
    ob_pkg::price_t    push_price_q;
    logic              full_q;
    logic [2:0]        rsp_type_q;
    ob_pkg::uid_t      rsp_uid_q;
    ob_pkg::uid_t      rsp_maker_q;
    ob_pkg::price_t    rsp_price_q;
    ob_pkg::quantity_t rsp_qty_q;

    logic              head_crosses;
    logic              eval_cross;
    logic              trade_hs;
    logic              ins_ok;
    ob_pkg::quantity_t fill;

    // The hit entry's price is not reported back on CANCEL_HIT.
    logic unused_hit_price;
    assign unused_hit_price = ^tbl_cancel_hit_tbl_w.price;

    always_comb begin
        if (RESTING_IS_BID) head_crosses = (tbl_head_r.price >= cmd_price_q);
        else                head_crosses = (tbl_head_r.price <= cmd_price_q);
        eval_cross = !rst && (state_q == EVAL) && tbl_head_vld_r && head_crosses
                     && (rem_q != '0);
        fill       = (rem_q < tbl_head_r.quantity) ? rem_q : tbl_head_r.quantity;
        trade_hs   = eval_cross && rsp_rdy;
        ins_ok     = !full_q && (cmd_qty_q != '0);
    end

    // Strobes decode from the registered state so CXL can sample the hit
    // result in the same cycle; everything is masked while rst is high.
    always_comb begin
        cmd_rdy           = !rst && (state_q == IDLE);
        tbl_insert        = !rst && (state_q == INS) && ins_ok;
        tbl_insert_tbl    = '0;
        if (tbl_insert) tbl_insert_tbl = '{uid: cmd_uid_q, price: cmd_price_q, quantity: cmd_qty_q};
        tbl_cancel        = !rst && (state_q == CXL);
        tbl_cancel_uid    = tbl_cancel ? cmd_uid_q : '0;
        tbl_head_pop      = trade_hs;
        tbl_head_push     = !rst && (state_q == PUSH);
        tbl_head_push_tbl = '0;
        if (tbl_head_push) tbl_head_push_tbl = '{uid: push_uid_q, price: push_price_q, quantity: resid_q};

        // A TRADE is presented straight from the settled head; it stays
        // stable because the head cannot move until the pop.
        if (eval_cross) begin
            rsp_vld       = 1'b1;
            rsp_type      = RSP_TRADE;
            rsp_uid       = cmd_uid_q;
            rsp_maker_uid = tbl_head_r.uid;
            rsp_price     = tbl_head_r.price;
            rsp_quantity  = fill;
        end else begin
            rsp_vld       = !rst && (state_q == RSP);
            rsp_type      = rsp_type_q;
            rsp_uid       = rsp_uid_q;
            rsp_maker_uid = rsp_maker_q;
            rsp_price     = rsp_price_q;
            rsp_quantity  = rsp_qty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_uid_q    <= '0;
            cmd_price_q  <= '0;
            cmd_qty_q    <= '0;
            rem_q        <= '0;
            resid_q      <= '0;
            push_uid_q   <= '0;
            push_price_q <= '0;
            full_q       <= 1'b0;
            rsp_type_q   <= '0;
            rsp_uid_q    <= '0;
            rsp_maker_q  <= '0;
            rsp_price_q  <= '0;
            rsp_qty_q    <= '0;
        end else begin
            full_q <= tbl_full_w;
            case (state_q)
                IDLE: begin
                    if (cmd_vld) begin
                        cmd_uid_q   <= cmd_uid;
                        cmd_price_q <= cmd_price;
                        cmd_qty_q   <= cmd_quantity;
                        rem_q       <= cmd_quantity;
                        case (cmd_opcode)
                            OP_INSERT: state_q <= INS;
                            OP_CANCEL: state_q <= CXL;
                            OP_MATCH:  state_q <= EVAL;
                            default: begin
                                rsp_type_q  <= RSP_REJECT;
                                rsp_uid_q   <= cmd_uid;
                                rsp_maker_q <= '0;
                                rsp_price_q <= cmd_price;
                                rsp_qty_q   <= '0;
                                state_q     <= RSP;
                            end
                        endcase
                    end
                end
                INS: begin
                    rsp_type_q  <= ins_ok ? RSP_INSERT_ACK : RSP_REJECT;
                    rsp_uid_q   <= cmd_uid_q;
                    rsp_maker_q <= '0;
                    rsp_price_q <= cmd_price_q;
                    rsp_qty_q   <= '0;
                    state_q     <= RSP;
                end
                CXL: begin
                    rsp_uid_q   <= cmd_uid_q;
                    rsp_price_q <= cmd_price_q;
                    if (tbl_cancel_hit_w) begin
                        rsp_type_q  <= RSP_CANCEL_HIT;
                        rsp_maker_q <= tbl_cancel_hit_tbl_w.uid;
                        rsp_qty_q   <= tbl_cancel_hit_tbl_w.quantity;
                    end else begin
                        rsp_type_q  <= RSP_CANCEL_MISS;
                        rsp_maker_q <= '0;
                        rsp_qty_q   <= '0;
                    end
                    state_q <= RSP;
                end
                EVAL: begin
                    if (!eval_cross) begin
                        rsp_type_q  <= RSP_MATCH_DONE;
                        rsp_uid_q   <= cmd_uid_q;
                        rsp_maker_q <= '0;
                        rsp_price_q <= cmd_price_q;
                        rsp_qty_q   <= rem_q;
                        state_q     <= RSP;
                    end else if (rsp_rdy) begin
                        rem_q <= rem_q - fill;
                        // Partial fill of the head: its remainder goes back to
                        // the front so it keeps time priority.
                        if (tbl_head_r.quantity > fill) begin
                            resid_q      <= tbl_head_r.quantity - fill;
                            push_uid_q   <= tbl_head_r.uid;
                            push_price_q <= tbl_head_r.price;
                            state_q      <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    rsp_type_q  <= RSP_MATCH_DONE;
                    rsp_uid_q   <= cmd_uid_q;
                    rsp_maker_q <= '0;
                    rsp_price_q <= cmd_price_q;
                    rsp_qty_q   <= '0;
                    state_q     <= RSP;
                end
                RSP: begin
                    if (rsp_rdy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OB_MK_MATCH_STATS_EN
    localparam int AW = $bits(ob_pkg::accum_quantity_t);
    logic [AW:0] vol_sum;
    assign vol_sum = {1'b0, stat_volume_r} + {{(AW + 1 - $bits(fill)){1'b0}}, fill};

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_trades_r <= '0;
            stat_volume_r <= '0;
        end else if (trade_hs) begin
            stat_trades_r <= (&stat_trades_r) ? stat_trades_r : stat_trades_r + 32'd1;
            stat_volume_r <= vol_sum[AW] ? '1 : vol_sum[AW-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_ob_mk_match.sv
`timescale 1ns/1ps
module tb_ob_mk_match;
    import ob_pkg::*;

    localparam int CAP = 8;
    localparam bit BID = 1'b1;
    localparam logic [2:0] T_ACK = 3'd0, T_REJ = 3'd1, T_HIT = 3'd2, T_MISS = 3'd3,
                           T_TRADE = 3'd4, T_DONE = 3'd5;

    typedef struct packed {
        logic [2:0] t;
        uid_t       uid;
        uid_t       maker;
        price_t     price;
        quantity_t  qty;
    } rsp_t;
    typedef struct packed {
        logic [1:0] k;   // 0 insert, 1 cancel, 2 pop, 3 push
        table_t     e;
    } strb_t;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_vld = 1'b0, cmd_rdy;
    logic [1:0] cmd_opcode = 2'b00;
    uid_t cmd_uid = '0;
    price_t cmd_price = '0;
    quantity_t cmd_quantity = '0;
    logic tbl_head_vld_r = 1'b0;
    table_t tbl_head_r = '0;
    logic tbl_full_w;
    logic tbl_head_pop, tbl_head_push, tbl_insert, tbl_cancel;
    table_t tbl_head_push_tbl, tbl_insert_tbl, tbl_cancel_hit_tbl_w;
    uid_t tbl_cancel_uid;
    logic tbl_cancel_hit_w;
    logic rsp_vld, rsp_rdy = 1'b0;
    logic [2:0] rsp_type;
    uid_t rsp_uid, rsp_maker_uid;
    price_t rsp_price;
    quantity_t rsp_quantity;
`ifdef OB_MK_MATCH_STATS_EN
    logic [31:0] stat_trades_r;
    accum_quantity_t stat_volume_r;
`endif

    int n_chk = 0, n_fail = 0;
    int rdy_mode = 1;          // 0 hold low, 1 hold high, 2 random
    logic force_full = 1'b0;
    int tbl_ver = 0;
    table_t tbl_q[$];          // emulated table driven by DUT strobes
    table_t mdl_q[$];          // reference table
    rsp_t exp_q[$];
    rsp_t obs_log[$];
    strb_t strb_log[$];
    longint mdl_trades = 0, mdl_vol = 0;

    always #5 clk = ~clk;

    ob_mk_match #(.RESTING_IS_BID(BID)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_opcode(cmd_opcode),
        .cmd_uid(cmd_uid), .cmd_price(cmd_price), .cmd_quantity(cmd_quantity),
        .tbl_head_vld_r(tbl_head_vld_r), .tbl_head_r(tbl_head_r), .tbl_full_w(tbl_full_w),
        .tbl_head_pop(tbl_head_pop), .tbl_head_push(tbl_head_push),
        .tbl_head_push_tbl(tbl_head_push_tbl), .tbl_insert(tbl_insert),
        .tbl_insert_tbl(tbl_insert_tbl), .tbl_cancel(tbl_cancel),
        .tbl_cancel_uid(tbl_cancel_uid), .tbl_cancel_hit_w(tbl_cancel_hit_w),
        .tbl_cancel_hit_tbl_w(tbl_cancel_hit_tbl_w),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_type(rsp_type), .rsp_uid(rsp_uid),
        .rsp_maker_uid(rsp_maker_uid), .rsp_price(rsp_price), .rsp_quantity(rsp_quantity)
`ifdef OB_MK_MATCH_STATS_EN
        , .stat_trades_r(stat_trades_r), .stat_volume_r(stat_volume_r)
`endif
    );

    // ---------------- table emulation ----------------
    always @(posedge clk) begin
        int idx;
        if (tbl_head_pop && tbl_q.size() > 0) void'(tbl_q.pop_front());
        if (tbl_head_push) tbl_q.push_front(tbl_head_push_tbl);
        if (tbl_insert) tbl_q.push_back(tbl_insert_tbl);
        if (tbl_cancel && tbl_cancel_hit_w) begin
            idx = -1;
            for (int i = 0; i < tbl_q.size(); i++)
                if (idx < 0 && tbl_q[i].uid == tbl_cancel_uid) idx = i;
            if (idx >= 0) tbl_q.delete(idx);
        end
        tbl_head_vld_r <= (tbl_q.size() != 0);
        tbl_head_r     <= (tbl_q.size() != 0) ? tbl_q[0] : '0;
        tbl_ver        <= tbl_ver + 1;
    end

    always @(tbl_cancel or tbl_cancel_uid or tbl_ver or force_full) begin
        tbl_cancel_hit_w     = 1'b0;
        tbl_cancel_hit_tbl_w = '0;
        if (tbl_cancel)
            for (int i = 0; i < tbl_q.size(); i++)
                if (!tbl_cancel_hit_w && tbl_q[i].uid == tbl_cancel_uid) begin
                    tbl_cancel_hit_w     = 1'b1;
                    tbl_cancel_hit_tbl_w = tbl_q[i];
                end
        tbl_full_w = force_full || (tbl_q.size() >= CAP);
    end

    initial forever begin
        @(posedge clk);
        #1;
        rsp_rdy = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t mk(logic [2:0] t, uid_t u, uid_t m, price_t p, quantity_t q);
        return {t, u, m, p, q};
    endfunction

    function automatic bit crosses(price_t hp, price_t cp);
        return BID ? (hp >= cp) : (hp <= cp);
    endfunction

    // Reference: whole-command outcome from the table contents at accept time.
    task automatic model_cmd(input logic [1:0] op, input uid_t u, input price_t p, input quantity_t q);
        quantity_t rem, fill;
        bit partial, found;
        table_t h;
        case (op)
            2'b01: begin
                if (force_full || mdl_q.size() >= CAP || q == 0) exp_q.push_back(mk(T_REJ, u, 0, p, 0));
                else begin
                    exp_q.push_back(mk(T_ACK, u, 0, p, 0));
                    mdl_q.push_back('{uid: u, price: p, quantity: q});
                end
            end
            2'b10: begin
                found = 0;
                for (int i = 0; i < mdl_q.size(); i++)
                    if (!found && mdl_q[i].uid == u) begin
                        found = 1;
                        exp_q.push_back(mk(T_HIT, u, mdl_q[i].uid, p, mdl_q[i].quantity));
                        mdl_q.delete(i);
                    end
                if (!found) exp_q.push_back(mk(T_MISS, u, 0, p, 0));
            end
            2'b11: begin
                rem = q;
                partial = 0;
                while (rem != 0 && mdl_q.size() > 0 && !partial && crosses(mdl_q[0].price, p)) begin
                    h = mdl_q[0];
                    fill = (rem < h.quantity) ? rem : h.quantity;
                    exp_q.push_back(mk(T_TRADE, u, h.uid, h.price, fill));
                    rem = rem - fill;
                    if (h.quantity > fill) begin
                        h.quantity = h.quantity - fill;
                        mdl_q[0] = h;
                        partial = 1;
                    end else void'(mdl_q.pop_front());
                end
                exp_q.push_back(mk(T_DONE, u, 0, p, rem));
            end
            default: exp_q.push_back(mk(T_REJ, u, 0, p, 0));
        endcase
    endtask

    task automatic send(input logic [1:0] op, input uid_t u, input price_t p, input quantity_t q);
        int n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 1000) begin @(negedge clk); n++; end
        if (!cmd_rdy) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_rdy_timeout: got 0 expected 1");
            return;
        end
        cmd_vld = 1'b1; cmd_opcode = op; cmd_uid = u; cmd_price = p; cmd_quantity = q;
        model_cmd(op, u, p, q);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0; cmd_opcode = 2'b00; cmd_uid = '0; cmd_price = '0; cmd_quantity = '0;
    endtask

    task automatic lat(input string name, input int exp_n);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rsp_vld && n < 50);
        check(name, n, exp_n);
    endtask

    task automatic wait_done();
        int n = 0;
        bit same;
        do begin @(negedge clk); n++; end while (!(exp_q.size() == 0 && cmd_rdy) && n < 3000);
        check("cmd_complete", (exp_q.size() == 0 && cmd_rdy), 1);
        same = (tbl_q.size() == mdl_q.size());
        for (int i = 0; i < tbl_q.size() && same; i++) same = (tbl_q[i] == mdl_q[i]);
        check("table_contents", same, 1);
    endtask

    task automatic chk_obs(input string name, input int back, input rsp_t e);
        if (obs_log.size() < back) check(name, 0, 1);
        else check(name, obs_log[obs_log.size() - back], e);
    endtask

    // ---------------- compare process ----------------
    rsp_t hold;
    bit hold_vld = 0;
    always @(negedge clk) begin
        rsp_t cur;
        int ns;
        cur = {rsp_type, rsp_uid, rsp_maker_uid, rsp_price, rsp_quantity};
        if (rst) begin
            hold_vld = 0;
            mdl_trades = 0;
            mdl_vol = 0;
        end else begin
            if (hold_vld) check("rsp_hold_stable", {rsp_vld, cur}, {1'b1, hold});
            ns = int'(tbl_insert) + int'(tbl_cancel) + int'(tbl_head_pop) + int'(tbl_head_push);
            check("strobe_onehot", (ns <= 1), 1);
            check("pop_iff_trade_hs", tbl_head_pop, (rsp_vld && rsp_rdy && rsp_type == T_TRADE));
            if (rsp_vld && rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got %0h expected none", cur);
                end else begin
                    check("rsp_payload", cur, exp_q[0]);
                    if (exp_q[0].t == T_TRADE) begin
                        mdl_trades++;
                        mdl_vol += exp_q[0].qty;
                    end
                    void'(exp_q.pop_front());
                end
                obs_log.push_back(cur);
                hold_vld = 0;
            end else if (rsp_vld) begin
                hold = cur;
                hold_vld = 1;
            end else hold_vld = 0;
            if (tbl_insert)    strb_log.push_back({2'd0, tbl_insert_tbl});
            if (tbl_cancel)    strb_log.push_back({2'd1, tbl_cancel_uid, 32'd0});
            if (tbl_head_pop)  strb_log.push_back({2'd2, 48'd0});
            if (tbl_head_push) strb_log.push_back({2'd3, tbl_head_push_tbl});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int sb;
        table_t snap[$];
        logic [1:0] op;
        uid_t u;
        int next_uid = 100;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_strobes", {tbl_insert, tbl_cancel, tbl_head_pop, tbl_head_push}, 4'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_rdy", cmd_rdy, 1);

        // INSERT, 2-cycle response
        rdy_mode = 1;
        sb = strb_log.size();
        send(2'b01, 1, 100, 10);
        lat("lat_insert", 2);
        wait_done();
        check("ins_strobe_cnt", strb_log.size() - sb, 1);
        if (strb_log.size() > sb) check("ins_strobe", strb_log[sb], {2'd0, 16'd1, 16'd100, 16'd10});
        chk_obs("ins_ack", 1, mk(T_ACK, 1, 0, 100, 0));

        // INSERT into a full table
        force_full = 1'b1;
        sb = strb_log.size();
        send(2'b01, 2, 100, 5);
        wait_done();
        force_full = 1'b0;
        check("full_no_strobe", strb_log.size() - sb, 0);
        chk_obs("full_reject", 1, mk(T_REJ, 2, 0, 100, 0));

        // Partial fill under 5 cycles of backpressure
        rdy_mode = 0;
        sb = strb_log.size();
        send(2'b11, 7, 95, 4);
        lat("lat_trade", 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", rsp_vld, 1);
            check("bp_payload", {rsp_type, rsp_uid, rsp_maker_uid, rsp_price, rsp_quantity},
                  mk(T_TRADE, 7, 1, 100, 4));
            check("bp_no_pop", tbl_head_pop, 0);
            @(negedge clk);
        end
        rdy_mode = 1;
        wait_done();
        chk_obs("partial_trade", 2, mk(T_TRADE, 7, 1, 100, 4));
        chk_obs("partial_done", 1, mk(T_DONE, 7, 0, 95, 0));
        check("partial_strobe_cnt", strb_log.size() - sb, 2);
        if (strb_log.size() >= sb + 2) begin
            check("partial_pop", strb_log[sb].k, 2'd2);
            check("partial_push", strb_log[sb + 1], {2'd3, 16'd1, 16'd100, 16'd6});
        end

        // CANCEL hit and miss
        send(2'b10, 1, 0, 0);
        lat("lat_cancel", 2);
        wait_done();
        chk_obs("cancel_hit", 1, mk(T_HIT, 1, 1, 0, 6));
        send(2'b10, 9, 0, 0);
        wait_done();
        chk_obs("cancel_miss", 1, mk(T_MISS, 9, 0, 0, 0));

        // Two full fills across two heads
        send(2'b01, 1, 100, 3);
        wait_done();
        send(2'b01, 2, 99, 5);
        wait_done();
        sb = strb_log.size();
        send(2'b11, 8, 99, 10);
        wait_done();
        chk_obs("sweep_t1", 3, mk(T_TRADE, 8, 1, 100, 3));
        chk_obs("sweep_t2", 2, mk(T_TRADE, 8, 2, 99, 5));
        chk_obs("sweep_done", 1, mk(T_DONE, 8, 0, 99, 2));
        check("sweep_pops", strb_log.size() - sb, 2);

        // MATCH on an empty table
        sb = strb_log.size();
        send(2'b11, 10, 50, 7);
        lat("lat_empty_match", 2);
        wait_done();
        chk_obs("empty_done", 1, mk(T_DONE, 10, 0, 50, 7));
        check("empty_no_strobe", strb_log.size() - sb, 0);

        // Reset while a TRADE is pending
        send(2'b01, 20, 100, 5);
        wait_done();
        snap = mdl_q;
        rdy_mode = 0;
        send(2'b11, 21, 100, 5);
        lat("lat_trade_pre_rst", 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_strobes", {tbl_insert, tbl_cancel, tbl_head_pop, tbl_head_push}, 4'b0);
        check("midrst_rsp_vld", rsp_vld, 0);
        check("midrst_cmd_rdy", cmd_rdy, 0);
        rst = 1'b0;
        mdl_q = snap;
        @(negedge clk);
        check("after_rst_cmd_rdy", cmd_rdy, 1);
        check("after_rst_rsp_vld", rsp_vld, 0);
        check("after_rst_strobes", {tbl_insert, tbl_cancel, tbl_head_pop, tbl_head_push}, 4'b0);
        rdy_mode = 2;
        wait_done();

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) force_full = ~force_full;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    send(2'b01, uid_t'(next_uid), price_t'($urandom_range(90, 110)),
                         quantity_t'($urandom_range(0, 12)));
                    next_uid++;
                end
                4, 5: begin
                    if (mdl_q.size() > 0 && $urandom_range(0, 3) != 0)
                        u = mdl_q[$urandom_range(0, mdl_q.size() - 1)].uid;
                    else u = uid_t'(16'hF000 + $urandom_range(0, 255));
                    send(2'b10, u, price_t'($urandom_range(0, 200)), '0);
                end
                6, 7, 8: send(2'b11, uid_t'(16'hE000 + n), price_t'($urandom_range(90, 110)),
                              quantity_t'($urandom_range(0, 25)));
                default: begin
                    op = 2'b00;
                    send(op, uid_t'(16'hD000 + n), price_t'($urandom_range(0, 200)),
                         quantity_t'($urandom_range(0, 20)));
                end
            endcase
            wait_done();
        end
        force_full = 1'b0;

`ifdef OB_MK_MATCH_STATS_EN
        check("stat_trades", stat_trades_r, mdl_trades);
        check("stat_volume", stat_volume_r, mdl_vol);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
